// File: rtl/kiwi_harness_pkg.sv
// Shared encodings and defaults for the Kiwi regression harness controller.
package kiwi_harness_pkg;

    localparam int TICK_W = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [7:0] IDLE_CODE_DEF    = 8'hFF;
    localparam logic [7:0] TIMEOUT_CODE_DEF = 8'hFE;

endpackage

// File: rtl/kiwi_sim_harness_ctrl_if.sv
// Harness-to-DUT-wrapper signal bundle; the controller takes the slave side.
interface kiwi_sim_harness_ctrl_if
    import kiwi_harness_pkg::*;
#(
    parameter int NCHAN = 3,
    parameter int WIDTH = 64
);
    logic [7:0]             hpr_abend_syndrome;
    logic                   stim_en;
    logic [NCHAN*WIDTH-1:0] stim_step;
    logic [NCHAN*WIDTH-1:0] stim_out;
    logic [TICK_W-1:0]      clock_ticks;
    logic [1:0]             state_o;
    logic [7:0]             final_code;
    logic                   done_pulse;
    logic                   finished;

    modport master (
        output hpr_abend_syndrome, stim_en, stim_step,
        input  stim_out, clock_ticks, state_o, final_code, done_pulse, finished
    );

    modport slave (
        input  hpr_abend_syndrome, stim_en, stim_step,
        output stim_out, clock_ticks, state_o, final_code, done_pulse, finished
    );
endinterface

// File: rtl/kiwi_stim_chan.sv
// One stimulus channel: free-running accumulator that wraps modulo 2^WIDTH.
module kiwi_stim_chan #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (en) begin
            value <= value + step;
        end
    end

endmodule

// File: rtl/kiwi_sim_harness_ctrl.sv
// Kiwi regression harness controller: stimulus generation, completion settle and timeout.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | DUT running, syndrome idle; stimulus live, timeout armed
//   ST_SETTLE  | non-idle syndrome seen; counting down before capture
//   ST_DONE    | code captured from syndrome; absorbing until reset
//   ST_TIMEOUT | tick limit reached in RUN; absorbing until reset
module kiwi_sim_harness_ctrl
    import kiwi_harness_pkg::*;
#(
    parameter int          NCHAN          = 3,
    parameter int          WIDTH          = 64,
    parameter int unsigned SETTLE         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  IDLE_CODE      = IDLE_CODE_DEF,
    parameter logic [7:0]  TIMEOUT_CODE   = TIMEOUT_CODE_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    kiwi_sim_harness_ctrl_if.slave  bus
);

    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE - 1);
    localparam bit                TO_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [TICK_W-1:0] TO_LAST     = TO_EN ? TICK_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t              state;
    logic [7:0]          settle_cnt;
    logic [TICK_W-1:0]   clock_ticks;
    logic [7:0]          final_code;
    logic                done_pulse;
    logic                finished;
    logic                chan_en;
    logic [NCHAN*WIDTH-1:0] stim_val;

    // Channels only advance while the run is live; they freeze once a result is latched.
    assign chan_en = bus.stim_en && ((state == ST_RUN) || (state == ST_SETTLE));

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        kiwi_stim_chan #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .reset (reset),
            .en    (chan_en),
            .step  (bus.stim_step[i*WIDTH +: WIDTH]),
            .value (stim_val[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            settle_cnt  <= '0;
            clock_ticks <= '0;
            final_code  <= IDLE_CODE;
            done_pulse  <= 1'b0;
            finished    <= 1'b0;
        end else begin
            if (clock_ticks != '1) begin
                clock_ticks <= clock_ticks + 1'b1;
            end
            done_pulse <= 1'b0;
            case (state)
                ST_RUN: begin
                    // Abend takes priority over a coincident timeout.
                    if (bus.hpr_abend_syndrome != IDLE_CODE) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (TO_EN && (clock_ticks == TO_LAST)) begin
                        state      <= ST_TIMEOUT;
                        final_code <= TIMEOUT_CODE;
                        done_pulse <= 1'b1;
                        finished   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state      <= ST_DONE;
                        final_code <= bus.hpr_abend_syndrome;
                        done_pulse <= 1'b1;
                        finished   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stim_out    = stim_val;
    assign bus.clock_ticks = clock_ticks;
    assign bus.state_o     = state;
    assign bus.final_code  = final_code;
    assign bus.done_pulse  = done_pulse;
    assign bus.finished    = finished;

endmodule
